// File: rtl/etx_pkg.sv
// Shared types and constants for the camera-to-Ethernet line arbiter.
// Holds the FSM state encoding, UDP/IP header overheads and a word-count helper.
package etx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_ARB,
        ST_XFER,
        ST_DRAIN,
        ST_GAP
    } state_t;

    localparam logic [15:0] UDP_OVH   = 16'd8;
    localparam logic [15:0] IPUDP_OVH = 16'd28;

    // 64-bit words needed to carry len bytes (partial word rounds up)
    function automatic logic [13:0] len_words(
        input logic [15:0] len
    );
        return {1'b0, len[15:3]} + {13'd0, |len[2:0]};
    endfunction

endpackage

// File: rtl/line_req_latch.sv
// Per-channel line request: 2-flop rising-edge detect on linedone + pending bit.
// Ports: clk, rst_n, i_linedone (level), i_clr (grant/abort clear), o_pend.
module line_req_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic i_linedone,
    input  logic i_clr,
    output logic o_pend
);

    logic r_s1;
    logic r_s2;
    logic r_pend;
    logic w_edge;

    assign w_edge = r_s1 & ~r_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_s1 <= i_linedone;
            r_s2 <= r_s1;
            // clear wins: an edge coinciding with the grant is a repeat
            if (i_clr)
                r_pend <= 1'b0;
            else if (w_edge)
                r_pend <= 1'b1;
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/etx_line_arbiter.sv
// Round-robin arbiter moving camera lines from two FIFOs into the ETX FIFO.
// Ports: clk/rst_n/en, linedone, cam_* (FIFO side), etx_* (TX side), lengths, abort_cnt.
module etx_line_arbiter
    import etx_pkg::*;
#(
    parameter int GAP_CYCLES   = 4,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  linedone,
    input  logic [63:0] cam_data0,
    input  logic [63:0] cam_data1,
    input  logic [15:0] cam_len0,
    input  logic [15:0] cam_len1,
    input  logic [1:0]  cam_empty,
    output logic [1:0]  cam_rden,
    input  logic        etx_full,
    input  logic        etx_empty,
    output logic [63:0] etx_din,
    output logic        ewr_en,
    output logic        etx_fifo_rst,
    output logic        etx_enable,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        line_src,
    output logic [15:0] abort_cnt
);

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_n;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_n;
    logic        r_en_d;
    logic        r_src;
    logic        r_last;
    logic [13:0] r_rem;
    logic [15:0] r_dlen;
    logic [15:0] r_tlen;
    logic [15:0] r_abort;
    logic        r_rden_d;

    logic [1:0]  w_pend;
    logic [1:0]  w_clr;
    logic        w_gsel;
    logic        w_grant;
    logic [15:0] w_len;
    logic [13:0] w_words;
    logic        w_rden;
    logic        w_abort;
    logic        w_xfer;

    for (genvar g = 0; g < 2; g++) begin : g_req
        line_req_latch u_req (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_linedone (linedone[g]),
            .i_clr      (w_clr[g]),
            .o_pend     (w_pend[g])
        );
    end

    // both pending: the channel not served last wins
    assign w_gsel  = (w_pend == 2'b11) ? ~r_last : w_pend[1];
    assign w_len   = w_gsel ? cam_len1 : cam_len0;
    assign w_words = len_words(w_len);

    assign w_xfer  = en && (r_state == ST_XFER)
                  && !etx_full && (r_rem != 14'd0);
    assign w_rden  = w_xfer && !cam_empty[r_src];
    assign w_abort = w_xfer && cam_empty[r_src];

    assign w_clr[0] = !en || (w_grant && !w_gsel);
    assign w_clr[1] = !en || (w_grant && w_gsel);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_grant   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (en && !r_en_d) begin
                    w_state_n = ST_FLUSH;
                    w_cnt_n   = 8'd0;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_cnt_n = 8'd0;
                    if (etx_empty)
                        w_state_n = ST_ARB;
                end else begin
                    w_cnt_n = r_cnt + 8'd1;
                end
            end
            ST_ARB: begin
                if (|w_pend) begin
                    w_grant   = 1'b1;
                    w_cnt_n   = 8'd0;
                    w_state_n = (w_words == 14'd0)
                              ? ST_GAP : ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_abort)
                    w_state_n = ST_DRAIN;
                else if (w_rden && r_rem == 14'd1)
                    w_state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_state_n = ST_GAP;
                w_cnt_n   = 8'd0;
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST)
                    w_state_n = ST_ARB;
                else
                    w_cnt_n = r_cnt + 8'd1;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
        if (!en) begin
            w_state_n = ST_IDLE;
            w_grant   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_en_d   <= 1'b0;
            r_src    <= 1'b0;
            r_last   <= 1'b1;
            r_rem    <= 14'd0;
            r_dlen   <= 16'd0;
            r_tlen   <= 16'd0;
            r_abort  <= 16'd0;
            r_rden_d <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_en_d   <= en;
            r_rden_d <= w_rden;
            if (w_grant) begin
                r_src  <= w_gsel;
                r_last <= w_gsel;
                r_rem  <= w_words;
                r_dlen <= w_len + UDP_OVH;
                r_tlen <= w_len + IPUDP_OVH;
            end else if (w_rden) begin
                r_rem <= r_rem - 14'd1;
            end
            if (w_abort && r_abort != 16'hFFFF)
                r_abort <= r_abort + 16'd1;
        end
    end

    assign cam_rden        = {w_rden & r_src, w_rden & ~r_src};
    assign ewr_en          = r_rden_d;
    assign etx_din         = r_src ? cam_data1 : cam_data0;
    assign etx_fifo_rst    = (r_state == ST_FLUSH);
    assign etx_enable      = 1'b1;
    assign tx_data_length  = r_dlen;
    assign tx_total_length = r_tlen;
    assign line_src        = r_src;
    assign abort_cnt       = r_abort;

endmodule

// File: tb/tb_etx_line_arbiter.sv
// Directed self-checking bench for etx_line_arbiter.
// Models both camera FIFOs; each task drives one scenario and checks inline.
module tb_etx_line_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  linedone;
    logic [63:0] cam_data0;
    logic [63:0] cam_data1;
    logic [15:0] cam_len0;
    logic [15:0] cam_len1;
    logic [1:0]  cam_empty;
    logic [1:0]  cam_rden;
    logic        etx_full;
    logic        etx_empty;
    logic [63:0] etx_din;
    logic        ewr_en;
    logic        etx_fifo_rst;
    logic        etx_enable;
    logic [15:0] tx_data_length;
    logic [15:0] tx_total_length;
    logic        line_src;
    logic [15:0] abort_cnt;

    int total = 0;
    int bad   = 0;

    int rd0 = 0;
    int rd1 = 0;
    int wr  = 0;
    int load0 = 0;
    int load1 = 0;
    logic [63:0] last_din;

    always #5 clk = ~clk;

    etx_line_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .linedone        (linedone),
        .cam_data0       (cam_data0),
        .cam_data1       (cam_data1),
        .cam_len0        (cam_len0),
        .cam_len1        (cam_len1),
        .cam_empty       (cam_empty),
        .cam_rden        (cam_rden),
        .etx_full        (etx_full),
        .etx_empty       (etx_empty),
        .etx_din         (etx_din),
        .ewr_en          (ewr_en),
        .etx_fifo_rst    (etx_fifo_rst),
        .etx_enable      (etx_enable),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .line_src        (line_src),
        .abort_cnt       (abort_cnt)
    );

    // camera FIFOs: words available = load - reads; data valid after rden
    assign cam_empty = {(rd1 >= load1), (rd0 >= load0)};

    always @(posedge clk) begin
        if (cam_rden[0]) begin
            cam_data0 <= {32'hC0C0_0000, 32'(rd0)};
            rd0 <= rd0 + 1;
        end
        if (cam_rden[1]) begin
            cam_data1 <= {32'hC1C1_0000, 32'(rd1)};
            rd1 <= rd1 + 1;
        end
        if (ewr_en) begin
            wr <= wr + 1;
            last_din <= etx_din;
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b0;
        linedone = 2'b00;
        etx_full = 1'b0;
        etx_empty = 1'b0;
        cam_len0 = 16'd0;
        cam_len1 = 16'd0;
        repeat (3) @(negedge clk);
        total++;
        if (cam_rden !== 2'b00) begin
            bad++;
            $display("FAIL rst_rden: got %b want 00", cam_rden);
        end
        total++;
        if (ewr_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_ewr: got %b want 0", ewr_en);
        end
        total++;
        if (etx_fifo_rst !== 1'b0) begin
            bad++;
            $display("FAIL rst_frst: got %b want 0", etx_fifo_rst);
        end
        total++;
        if (tx_data_length !== 16'd0) begin
            bad++;
            $display("FAIL rst_dlen: got %0d want 0", tx_data_length);
        end
        total++;
        if (tx_total_length !== 16'd0) begin
            bad++;
            $display("FAIL rst_tlen: got %0d want 0", tx_total_length);
        end
        total++;
        if (line_src !== 1'b0) begin
            bad++;
            $display("FAIL rst_src: got %b want 0", line_src);
        end
        total++;
        if (abort_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rst_abort: got %0d want 0", abort_cnt);
        end
        total++;
        if (etx_enable !== 1'b1) begin
            bad++;
            $display("FAIL etx_enable: got %b want 1", etx_enable);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (etx_fifo_rst !== 1'b0) begin
            bad++;
            $display("FAIL idle_frst: got %b want 0", etx_fifo_rst);
        end
    endtask

    task automatic test_flush;
        int cnt;
        bit seen;
        bit ended;
        cnt = 0;
        seen = 0;
        ended = 0;
        en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (etx_fifo_rst) begin
                cnt++;
                seen = 1;
            end else if (seen) begin
                ended = 1;
                break;
            end
            if (i == 20)
                etx_empty = 1'b1;
        end
        total++;
        if (!ended || cnt != 24) begin
            bad++;
            $display("FAIL flush_len: got %0d want 24 ended=%0d",
                     cnt, ended);
        end
    endtask

    task automatic test_single;
        int s_rd0, s_rd1, s_wr;
        s_rd0 = rd0;
        s_rd1 = rd1;
        s_wr = wr;
        cam_len0 = 16'd1024;
        load0 = rd0 + 128;
        linedone[0] = 1'b1;
        repeat (3) @(negedge clk);
        linedone[0] = 1'b0;
        repeat (300) @(negedge clk);
        total++;
        if (rd0 - s_rd0 != 128) begin
            bad++;
            $display("FAIL single_rd: got %0d want 128", rd0 - s_rd0);
        end
        total++;
        if (wr - s_wr != 128) begin
            bad++;
            $display("FAIL single_wr: got %0d want 128", wr - s_wr);
        end
        total++;
        if (rd1 != s_rd1) begin
            bad++;
            $display("FAIL single_rd1: got %0d want 0", rd1 - s_rd1);
        end
        total++;
        if (tx_data_length !== 16'd1032) begin
            bad++;
            $display("FAIL single_dlen: got %0d want 1032",
                     tx_data_length);
        end
        total++;
        if (tx_total_length !== 16'd1052) begin
            bad++;
            $display("FAIL single_tlen: got %0d want 1052",
                     tx_total_length);
        end
        total++;
        if (last_din !== {32'hC0C0_0000, 32'(rd0 - 1)}) begin
            bad++;
            $display("FAIL single_din: got %h want %h", last_din,
                     {32'hC0C0_0000, 32'(rd0 - 1)});
        end
        total++;
        if (abort_cnt !== 16'd0) begin
            bad++;
            $display("FAIL single_abort: got %0d want 0", abort_cnt);
        end
    endtask

    task automatic test_both;
        int s_rd0, s_rd1;
        int first0, last0, first1;
        logic src0, src1;
        rst_n = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        repeat (12) @(negedge clk);
        s_rd0 = rd0;
        s_rd1 = rd1;
        first0 = -1;
        last0 = -1;
        first1 = -1;
        src0 = 1'bx;
        src1 = 1'bx;
        cam_len0 = 16'd16;
        cam_len1 = 16'd24;
        load0 = rd0 + 2;
        load1 = rd1 + 3;
        linedone = 2'b11;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 2)
                linedone = 2'b00;
            if (cam_rden[0]) begin
                if (first0 < 0) begin
                    first0 = i;
                    src0 = line_src;
                end
                last0 = i;
            end
            if (cam_rden[1] && first1 < 0) begin
                first1 = i;
                src1 = line_src;
            end
        end
        total++;
        if (first0 < 0 || first1 <= first0) begin
            bad++;
            $display("FAIL both_order: got ch0@%0d ch1@%0d want ch0 first",
                     first0, first1);
        end
        total++;
        if (first1 - last0 != 7) begin
            bad++;
            $display("FAIL both_gap: got %0d want 7", first1 - last0);
        end
        total++;
        if (src0 !== 1'b0 || src1 !== 1'b1) begin
            bad++;
            $display("FAIL both_src: got %b,%b want 0,1", src0, src1);
        end
        total++;
        if (rd0 - s_rd0 != 2 || rd1 - s_rd1 != 3) begin
            bad++;
            $display("FAIL both_rd: got %0d,%0d want 2,3",
                     rd0 - s_rd0, rd1 - s_rd1);
        end
        total++;
        if (tx_data_length !== 16'd32 || tx_total_length !== 16'd52) begin
            bad++;
            $display("FAIL both_len: got %0d,%0d want 32,52",
                     tx_data_length, tx_total_length);
        end
    endtask

    task automatic test_stall;
        int s_rd0, s_wr;
        int stall, viol;
        s_rd0 = rd0;
        s_wr = wr;
        stall = 0;
        viol = 0;
        cam_len0 = 16'd1000;
        load0 = rd0 + 125;
        linedone[0] = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i == 2)
                linedone[0] = 1'b0;
            if (stall == 0 && rd0 - s_rd0 >= 20) begin
                etx_full = 1'b1;
                stall = 1;
            end else if (stall >= 1 && stall <= 50) begin
                if (cam_rden !== 2'b00)
                    viol++;
                stall++;
                if (stall == 51)
                    etx_full = 1'b0;
            end
        end
        total++;
        if (stall != 51 || viol != 0) begin
            bad++;
            $display("FAIL stall_rden: got viol=%0d stall=%0d want 0,51",
                     viol, stall);
        end
        total++;
        if (rd0 - s_rd0 != 125 || wr - s_wr != 125) begin
            bad++;
            $display("FAIL stall_cnt: got rd=%0d wr=%0d want 125,125",
                     rd0 - s_rd0, wr - s_wr);
        end
        total++;
        if (abort_cnt !== 16'd0) begin
            bad++;
            $display("FAIL stall_abort: got %0d want 0", abort_cnt);
        end
    endtask

    task automatic test_abort;
        int s_rd0, s_rd1, s_wr;
        int wr_at;
        s_rd0 = rd0;
        s_rd1 = rd1;
        s_wr = wr;
        wr_at = -1;
        cam_len0 = 16'd1024;
        load0 = rd0 + 10;
        cam_len1 = 16'd16;
        load1 = rd1 + 2;
        linedone[0] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 2)
                linedone[0] = 1'b0;
            if (i == 5)
                linedone[1] = 1'b1;
            if (i == 8)
                linedone[1] = 1'b0;
            if (cam_rden[1] && wr_at < 0)
                wr_at = wr - s_wr;
        end
        total++;
        if (abort_cnt !== 16'd1) begin
            bad++;
            $display("FAIL abort_cnt: got %0d want 1", abort_cnt);
        end
        total++;
        if (rd0 - s_rd0 != 10 || wr_at != 10) begin
            bad++;
            $display("FAIL abort_words: got rd=%0d wr=%0d want 10,10",
                     rd0 - s_rd0, wr_at);
        end
        total++;
        if (rd1 - s_rd1 != 2 || line_src !== 1'b1) begin
            bad++;
            $display("FAIL abort_next: got rd1=%0d src=%b want 2,1",
                     rd1 - s_rd1, line_src);
        end
        total++;
        if (tx_data_length !== 16'd24) begin
            bad++;
            $display("FAIL abort_dlen: got %0d want 24", tx_data_length);
        end
    endtask

    task automatic test_en_drop;
        int s_rd0, s_rd1, s_wr;
        int seen;
        bit dropped, chk;
        s_rd0 = rd0;
        s_rd1 = rd1;
        s_wr = wr;
        seen = 0;
        dropped = 0;
        chk = 0;
        cam_len0 = 16'd13;
        cam_len1 = 16'd16;
        load0 = rd0 + 2;
        load1 = rd1 + 2;
        linedone = 2'b11;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2)
                linedone = 2'b00;
            if (dropped && !chk) begin
                chk = 1;
                total++;
                if (cam_rden !== 2'b00) begin
                    bad++;
                    $display("FAIL drop_rden: got %b want 00", cam_rden);
                end
            end
            if (!dropped && cam_rden[0]) begin
                seen++;
                if (seen == 2) begin
                    en = 1'b0;
                    dropped = 1;
                end
            end
        end
        total++;
        if (rd0 - s_rd0 != 1 || wr - s_wr != 1) begin
            bad++;
            $display("FAIL drop_cnt: got rd=%0d wr=%0d want 1,1",
                     rd0 - s_rd0, wr - s_wr);
        end
        s_rd0 = rd0;
        s_wr = wr;
        load0 = rd0 + 2;
        en = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (rd1 != s_rd1 || rd0 != s_rd0) begin
            bad++;
            $display("FAIL drop_pend: got rd0=%0d rd1=%0d want 0,0",
                     rd0 - s_rd0, rd1 - s_rd1);
        end
        linedone[0] = 1'b1;
        repeat (3) @(negedge clk);
        linedone[0] = 1'b0;
        repeat (30) @(negedge clk);
        total++;
        if (rd0 - s_rd0 != 2 || wr - s_wr != 2) begin
            bad++;
            $display("FAIL reen_cnt: got rd=%0d wr=%0d want 2,2",
                     rd0 - s_rd0, wr - s_wr);
        end
        total++;
        if (tx_data_length !== 16'd21 || tx_total_length !== 16'd41) begin
            bad++;
            $display("FAIL reen_len: got %0d,%0d want 21,41",
                     tx_data_length, tx_total_length);
        end
    endtask

    initial begin
        test_reset();
        test_flush();
        test_single();
        test_both();
        test_stall();
        test_abort();
        test_en_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
